// File: rtl/psum_accum_xnor_pkg.sv
// Shared widths and FSM encoding for the PSUM accumulator slice.
// Optional feature macro: PSUM_ACC_SAT_EN (saturating accumulation).
package psum_accum_xnor_pkg;

  localparam int unsigned BITS_SIP_DOT_ADDER = 16;
  localparam int unsigned BITS_PSUM_ACC      = 24;
  localparam int unsigned BITS_PSUM_LEN      = 8;
  localparam int unsigned BITS_PSUM_SHIFT    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_HOLD  = 2'b10
  } psum_state_e;

endpackage

// File: rtl/psum_accum_xnor_shift_add.sv
// Combinational sign-extend, significance shift and add of one PSUM into an accumulator.
// With PSUM_ACC_SAT_EN the sum clamps to the signed accumulator range and flags the clamp.
module psum_accum_xnor_shift_add #(
  parameter int unsigned BITS_PSUM  = 16,
  parameter int unsigned BITS_ACC   = 24,
  parameter int unsigned BITS_SHIFT = 3
) (
  input  logic signed [BITS_ACC-1:0]   acc_i,
  input  logic signed [BITS_PSUM-1:0]  psum_i,
  input  logic        [BITS_SHIFT-1:0] shift_i,
`ifdef PSUM_ACC_SAT_EN
  output logic                         sat_c,
`endif
  output logic signed [BITS_ACC-1:0]   sum_c
);

`ifdef PSUM_ACC_SAT_EN
  // Exact sum in a width that cannot overflow, so the clamp sees the true value.
  localparam int unsigned BITS_WIDE = BITS_ACC + (1 << BITS_SHIFT);

  logic signed [BITS_WIDE-1:0] psum_w;
  logic signed [BITS_WIDE-1:0] sum_w;
  logic                        ovf;

  assign psum_w = BITS_WIDE'(psum_i);
  assign sum_w  = BITS_WIDE'(acc_i) + (psum_w <<< shift_i);
  assign ovf    = !((&sum_w[BITS_WIDE-1:BITS_ACC-1]) || !(|sum_w[BITS_WIDE-1:BITS_ACC-1]));
  assign sat_c  = ovf;

  always_comb begin
    sum_c = sum_w[BITS_ACC-1:0];
    if (ovf) begin
      sum_c = sum_w[BITS_WIDE-1] ? {1'b1, {(BITS_ACC-1){1'b0}}}
                                 : {1'b0, {(BITS_ACC-1){1'b1}}};
    end
  end
`else
  logic signed [BITS_ACC-1:0] psum_x;

  assign psum_x = BITS_ACC'(psum_i);
  assign sum_c  = acc_i + (psum_x <<< shift_i);
`endif

endmodule

// File: rtl/psum_accum_xnor.sv
// Accumulates a programmed number of shifted PE partial sums and offers the result on valid/ready.
// Optional feature macro: PSUM_ACC_SAT_EN (clamp instead of wrap, sticky o_sat).
module psum_accum_xnor
  import psum_accum_xnor_pkg::*;
#(
  parameter int unsigned BITS_PSUM  = BITS_SIP_DOT_ADDER,
  parameter int unsigned BITS_ACC   = BITS_PSUM_ACC,
  parameter int unsigned BITS_LEN   = BITS_PSUM_LEN,
  parameter int unsigned BITS_SHIFT = BITS_PSUM_SHIFT
) (
  input  logic                         CLK,
  input  logic                         RSTn,
  input  logic                         i_start,
  input  logic        [BITS_LEN-1:0]   i_len,
  input  logic                         i_psum_valid,
  input  logic signed [BITS_PSUM-1:0]  i_psum,
  input  logic        [BITS_SHIFT-1:0] i_shift,
  output logic                         o_acc_valid,
  input  logic                         i_acc_ready,
  output logic signed [BITS_ACC-1:0]   o_acc,
  output logic                         o_busy,
  output logic                         o_err,
  output logic                         o_sat
);

  psum_state_e                state_q;
  logic signed [BITS_ACC-1:0] acc_q;
  logic signed [BITS_ACC-1:0] acc_d;
  logic        [BITS_LEN-1:0] cnt_q;
  logic        [BITS_LEN-1:0] len_q;
  logic                       start_ok;
  logic                       accept_start;
  logic                       last_psum;
`ifdef PSUM_ACC_SAT_EN
  logic                       sat_c;
`endif

  // A start is taken in IDLE, as a restart in ACCUM, or together with a result handoff in HOLD.
  assign start_ok     = i_start && (i_len != '0);
  assign accept_start = start_ok && ((state_q != ST_HOLD) || i_acc_ready);
  assign last_psum    = (cnt_q == (len_q - BITS_LEN'(1)));
  assign o_busy       = (state_q != ST_IDLE);

  psum_accum_xnor_shift_add #(
    .BITS_PSUM  (BITS_PSUM),
    .BITS_ACC   (BITS_ACC),
    .BITS_SHIFT (BITS_SHIFT)
  ) u_shift_add (
    .acc_i   (acc_q),
    .psum_i  (i_psum),
    .shift_i (i_shift),
`ifdef PSUM_ACC_SAT_EN
    .sat_c   (sat_c),
`endif
    .sum_c   (acc_d)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      o_acc       <= '0;
      o_acc_valid <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_psum_valid) o_err <= 1'b1;
        end
        ST_ACCUM: begin
          // A PSUM coinciding with a restart is dropped without raising o_err.
          if (i_psum_valid && !start_ok) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + BITS_LEN'(1);
            if (last_psum) begin
              o_acc       <= acc_d;
              o_acc_valid <= 1'b1;
              state_q     <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (i_psum_valid) o_err <= 1'b1;
          if (i_acc_ready) begin
            o_acc_valid <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      // Placed last so an accepted start overrides the state and error updates above.
      if (accept_start) begin
        state_q <= ST_ACCUM;
        len_q   <= i_len;
        acc_q   <= '0;
        cnt_q   <= '0;
        o_err   <= 1'b0;
      end
    end
  end

`ifdef PSUM_ACC_SAT_EN
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      o_sat <= 1'b0;
    end else if (accept_start) begin
      o_sat <= 1'b0;
    end else if ((state_q == ST_ACCUM) && i_psum_valid && sat_c) begin
      o_sat <= 1'b1;
    end
  end
`else
  assign o_sat = 1'b0;
`endif

endmodule

// File: tb/tb_psum_accum_xnor.sv
// Self-checking bench for psum_accum_xnor: vector table, corner sequences and random transactions.
module tb_psum_accum_xnor;
  import psum_accum_xnor_pkg::*;

  localparam int unsigned BP = BITS_SIP_DOT_ADDER;
  localparam int unsigned BA = BITS_PSUM_ACC;
  localparam int unsigned BL = BITS_PSUM_LEN;
  localparam int unsigned BS = BITS_PSUM_SHIFT;
`ifdef PSUM_ACC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic                 CLK = 1'b0;
  logic                 RSTn = 1'b0;
  logic                 start = 1'b0;
  logic        [BL-1:0] ilen = '0;
  logic                 pv = 1'b0;
  logic signed [BP-1:0] psum = '0;
  logic        [BS-1:0] shift = '0;
  logic                 ready = 1'b0;
  logic                 valid;
  logic signed [BA-1:0] acc;
  logic                 busy, err, sat;

  logic                 s8_start = 1'b0;
  logic        [BL-1:0] s8_len = '0;
  logic                 s8_pv = 1'b0;
  logic signed [7:0]    s8_psum = '0;
  logic                 s8_valid;
  logic signed [7:0]    s8_acc;
  logic                 s8_busy, s8_err, s8_sat;

  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  psum_accum_xnor u_dut (
    .CLK(CLK), .RSTn(RSTn), .i_start(start), .i_len(ilen), .i_psum_valid(pv),
    .i_psum(psum), .i_shift(shift), .o_acc_valid(valid), .i_acc_ready(ready),
    .o_acc(acc), .o_busy(busy), .o_err(err), .o_sat(sat)
  );

  psum_accum_xnor #(.BITS_PSUM(8), .BITS_ACC(8)) u_dut8 (
    .CLK(CLK), .RSTn(RSTn), .i_start(s8_start), .i_len(s8_len), .i_psum_valid(s8_pv),
    .i_psum(s8_psum), .i_shift(3'd0), .o_acc_valid(s8_valid), .i_acc_ready(1'b1),
    .o_acc(s8_acc), .o_busy(s8_busy), .o_err(s8_err), .o_sat(s8_sat)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_start(input int len);
    start = 1'b1;
    ilen  = BL'(len);
    step();
    start = 1'b0;
  endtask

  task automatic do_psum(input int p, input int s);
    pv    = 1'b1;
    psum  = BP'(p);
    shift = BS'(s);
    step();
    pv    = 1'b0;
  endtask

  task automatic accept();
    ready = 1'b1;
    step();
    ready = 1'b0;
  endtask

  // Reference: exact integer add, then wrap modulo 2^bits or clamp to the signed range.
  function automatic longint ref_add(input longint a, input longint term, input int unsigned bits,
                                     output bit clamped);
    longint s, hi, lo, m;
    s = a + term;
    m = longint'(1) <<< bits;
    hi = (m >>> 1) - 1;
    lo = -(hi + 1);
    clamped = 1'b0;
    if (SAT_EN) begin
      if (s > hi) begin s = hi; clamped = 1'b1; end
      else if (s < lo) begin s = lo; clamped = 1'b1; end
    end else begin
      s = s & (m - 1);
      if (s > hi) s = s - m;
    end
    return s;
  endfunction

  typedef struct {
    int     len;
    int     p[4];
    int     s[4];
    longint exp_wrap;
    longint exp_sat;
    bit     sat_flag;
  } vec_t;

  vec_t tbl[6];

  initial begin
    longint m_acc;
    bit     m_sat, c;
    int     len, p, s, hold;

    tbl[0] = '{4, '{5, -3, 7, 1},                '{0, 0, 0, 0}, 10, 10, 1'b0};
    tbl[1] = '{2, '{3, -2, 0, 0},                '{1, 0, 0, 0}, 4, 4, 1'b0};
    tbl[2] = '{1, '{-1, 0, 0, 0},                '{0, 0, 0, 0}, -1, -1, 1'b0};
    tbl[3] = '{3, '{-32768, -32768, 1, 0},       '{7, 7, 0, 0}, -8388607, -8388607, 1'b0};
    tbl[4] = '{3, '{32767, 32767, 32767, 0},     '{7, 7, 7, 0}, -4194688, 8388607, 1'b1};
    tbl[5] = '{4, '{-32768, -32768, -32768, 100}, '{7, 7, 7, 0}, 4194404, -8388508, 1'b1};

    repeat (2) @(posedge CLK);
    #1;
    chk("reset_acc", acc, 0);
    chk("reset_valid", valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_err", err, 0);
    chk("reset_sat", sat, 0);
    RSTn = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      do_start(tbl[i].len);
      for (int k = 0; k < tbl[i].len; k++) begin
        do_psum(tbl[i].p[k], tbl[i].s[k]);
        if (k < tbl[i].len - 1) chk($sformatf("tbl%0d_early_valid", i), valid, 0);
      end
      chk($sformatf("tbl%0d_valid", i), valid, 1);
      chk($sformatf("tbl%0d_acc", i), acc, SAT_EN ? tbl[i].exp_sat : tbl[i].exp_wrap);
      chk($sformatf("tbl%0d_sat", i), sat, SAT_EN ? longint'(tbl[i].sat_flag) : 0);
      accept();
      chk($sformatf("tbl%0d_drop_valid", i), valid, 0);
      chk($sformatf("tbl%0d_idle", i), busy, 0);
    end

    // Asynchronous reset in the middle of an accumulation
    do_start(4);
    do_psum(5, 0);
    do_psum(-3, 0);
    RSTn = 1'b0;
    #1;
    chk("midrst_acc", acc, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", valid, 0);
    #2;
    RSTn = 1'b1;
    do_start(2);
    do_psum(4, 0);
    do_psum(4, 0);
    chk("postrst_acc", acc, 8);
    accept();

    // Result held while downstream stalls; stray PSUM in HOLD sets o_err
    do_start(2);
    do_psum(3, 1);
    do_psum(-2, 0);
    for (int k = 0; k < 5; k++) begin
      pv = (k == 2);
      step();
      pv = 1'b0;
      chk($sformatf("stall%0d_valid", k), valid, 1);
      chk($sformatf("stall%0d_acc", k), acc, 4);
    end
    chk("hold_err", err, 1);
    accept();
    chk("stall_drop", valid, 0);

    // Back-to-back: handoff and new start in the same cycle
    do_start(1);
    do_psum(7, 0);
    chk("b2b_first", acc, 7);
    ready = 1'b1; start = 1'b1; ilen = BL'(1);
    step();
    ready = 1'b0; start = 1'b0;
    chk("b2b_valid_low", valid, 0);
    chk("b2b_busy", busy, 1);
    do_psum(-1, 0);
    chk("b2b_valid", valid, 1);
    chk("b2b_acc", acc, -1);
    accept();

    // PSUM in IDLE, zero-length start ignored, real start clears o_err
    pv = 1'b1; psum = BP'(5);
    step();
    pv = 1'b0;
    chk("idle_err", err, 1);
    chk("idle_busy", busy, 0);
    do_start(0);
    chk("len0_busy", busy, 0);
    chk("len0_err", err, 1);
    do_start(1);
    chk("start_clr_err", err, 0);
    do_psum(9, 0);
    chk("len1_acc", acc, 9);
    accept();

    // Restart with a same-cycle PSUM: dropped, no error
    do_start(3);
    do_psum(100, 0);
    start = 1'b1; ilen = BL'(2); pv = 1'b1; psum = BP'(50);
    step();
    start = 1'b0; pv = 1'b0;
    chk("restart_err", err, 0);
    do_psum(1, 0);
    chk("restart_early", valid, 0);
    do_psum(2, 0);
    chk("restart_acc", acc, 3);
    accept();

    // Longest programmable length: counter must not wrap early
    do_start(255);
    for (int k = 0; k < 255; k++) begin
      do_psum(1, 0);
      if (k == 253) chk("len255_early", valid, 0);
    end
    chk("len255_valid", valid, 1);
    chk("len255_acc", acc, 255);
    accept();

    // Random transactions against the reference model
    for (int t = 0; t < 25; t++) begin
      len = int'($urandom_range(6, 1));
      do_start(len);
      m_acc = 0;
      m_sat = 1'b0;
      for (int k = 0; k < len; k++) begin
        repeat ($urandom_range(2, 0)) step();
        p = int'($urandom_range(65535, 0)) - 32768;
        s = int'($urandom_range(7, 0));
        m_acc = ref_add(m_acc, longint'(p) <<< s, BA, c);
        m_sat = m_sat | c;
        do_psum(p, s);
      end
      hold = int'($urandom_range(3, 0));
      repeat (hold) step();
      chk($sformatf("rand%0d_valid", t), valid, 1);
      chk($sformatf("rand%0d_acc", t), acc, m_acc);
      chk($sformatf("rand%0d_sat", t), sat, longint'(m_sat));
      accept();
      chk($sformatf("rand%0d_drop", t), valid, 0);
    end

    // Narrow accumulator: 100 + 100 in 8 bits
    s8_start = 1'b1; s8_len = BL'(2);
    step();
    s8_start = 1'b0; s8_pv = 1'b1; s8_psum = 8'sd100;
    step();
    step();
    s8_pv = 1'b0;
    chk("acc8_valid", s8_valid, 1);
    chk("acc8_acc", s8_acc, SAT_EN ? 127 : -56);
    chk("acc8_sat", s8_sat, SAT_EN ? 1 : 0);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
